// File: rtl/alu_iter.sv
// Execute unit: single-cycle logic/arithmetic ops plus an iterative
// arithmetic right shift (one bit per clock) behind a start/busy/done handshake.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SRA = 4'b1000,
    OP_LUI = 4'b1100
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [4:0]       r_cnt;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic [WIDTH-1:0] w_shifted;
  logic             w_launch_shift;
  logic             w_single_done;
  logic             w_shift_done;

  assign w_sum     = src1_i + src2_i;
  assign w_diff    = src1_i - src2_i;
  assign w_shifted = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (ctrl_i)
      OP_AND: w_alu_res = src1_i & src2_i;
      OP_OR:  w_alu_res = src1_i | src2_i;
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      // Exact signed compare; the subtraction sign is wrong on overflow.
      OP_SLT: w_alu_res[0] = ($signed(src1_i) < $signed(src2_i));
      OP_SRA: w_alu_res = src2_i;
      OP_LUI: w_alu_res = {src2_i[15:0], {(WIDTH-16){1'b0}}};
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_launch_shift = 1'b0;
    w_single_done  = 1'b0;
    w_shift_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if ((ctrl_i == OP_SRA) && (shamt_i != 5'd0)) begin
            w_launch_shift = 1'b1;
            w_state_nxt    = S_SHIFT;
          end else begin
            w_single_done  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt == 5'd1) begin
          w_shift_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_shreg    <= '0;
      r_cnt      <= '0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      done_o <= w_single_done | w_shift_done;
      if (w_launch_shift) begin
        r_shreg <= src2_i;
        r_cnt   <= shamt_i;
      end else if (r_state == S_SHIFT) begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt - 5'd1;
      end
      if (w_single_done) begin
        result_o   <= w_alu_res;
        zero_o     <= (w_alu_res == '0);
        overflow_o <= w_alu_ovf;
      end else if (w_shift_done) begin
        result_o   <= w_shifted;
        zero_o     <= (w_shifted == '0);
        overflow_o <= 1'b0;
      end
    end
  end

  assign busy_o = (r_state == S_SHIFT);

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: each task drives one scenario and checks
// outputs #1 after the rising edge against hand-computed values.
module tb_alu_iter;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  // flag order: {busy, done, zero, overflow}
  logic [3:0] flags;
  assign flags = {busy_o, done_o, zero_o, overflow_o};

  alu_iter #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .ctrl_i     (ctrl_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .shamt_i    (shamt_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s);
    start_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    shamt_i = s;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    launch(4'b0010, 32'h1, 32'h1, 5'd0);
    tick();
    tick();
    checks++;
    if (flags !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", flags, 4'b0010);
    end
    checks++;
    if (result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected %h", result_o, 32'h0);
    end
    rst_i   = 1'b1;
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_addsub();
    launch(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    tick();
    start_i = 1'b0;
    checks++;
    if (result_o !== 32'h80000000) begin
      errors++;
      $display("FAIL add_ovf_result: got %h expected %h", result_o, 32'h80000000);
    end
    checks++;
    if (flags !== 4'b0101) begin
      errors++;
      $display("FAIL add_ovf_flags: got %b expected %b", flags, 4'b0101);
    end
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL add_done_width: got %b expected %b", done_o, 1'b0);
    end
    launch(4'b0110, 32'd5, 32'd5, 5'd0);
    tick();
    checks++;
    if ({result_o, flags} !== {32'h0, 4'b0110}) begin
      errors++;
      $display("FAIL sub_zero: got %h/%b expected %h/%b", result_o, flags, 32'h0, 4'b0110);
    end
    launch(4'b0110, 32'h80000000, 32'h1, 5'd0);
    tick();
    checks++;
    if ({result_o, flags} !== {32'h7FFFFFFF, 4'b0101}) begin
      errors++;
      $display("FAIL sub_ovf: got %h/%b expected %h/%b", result_o, flags, 32'h7FFFFFFF, 4'b0101);
    end
    launch(4'b0010, 32'hFFFFFFFF, 32'h1, 5'd0);
    tick();
    start_i = 1'b0;
    checks++;
    if ({result_o, flags} !== {32'h0, 4'b0110}) begin
      errors++;
      $display("FAIL add_wrap_noovf: got %h/%b expected %h/%b", result_o, flags, 32'h0, 4'b0110);
    end
  endtask

  task automatic test_slt_lui();
    launch(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0);
    tick();
    checks++;
    if ({result_o, flags} !== {32'h1, 4'b0100}) begin
      errors++;
      $display("FAIL slt_neg: got %h/%b expected %h/%b", result_o, flags, 32'h1, 4'b0100);
    end
    launch(4'b0111, 32'h7FFFFFFF, 32'h80000000, 5'd0);
    tick();
    checks++;
    if ({result_o, flags} !== {32'h0, 4'b0110}) begin
      errors++;
      $display("FAIL slt_extreme: got %h/%b expected %h/%b", result_o, flags, 32'h0, 4'b0110);
    end
    launch(4'b1100, 32'hFFFFFFFF, 32'h00001234, 5'd0);
    tick();
    start_i = 1'b0;
    checks++;
    if ({result_o, flags} !== {32'h12340000, 4'b0100}) begin
      errors++;
      $display("FAIL lui: got %h/%b expected %h/%b", result_o, flags, 32'h12340000, 4'b0100);
    end
    tick();
  endtask

  task automatic test_sra();
    launch(4'b1000, 32'h0, 32'h80000010, 5'd4);
    tick();
    // Mid-shift input changes plus a second start that must be ignored
    launch(4'b0010, 32'd2, 32'd3, 5'd1);
    checks++;
    if ({result_o, flags} !== {32'h12340000, 4'b1000}) begin
      errors++;
      $display("FAIL sra_launch: got %h/%b expected %h/%b", result_o, flags, 32'h12340000, 4'b1000);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({busy_o, done_o} !== 2'b10) begin
        errors++;
        $display("FAIL sra_busy_%0d: got %b expected %b", i, {busy_o, done_o}, 2'b10);
      end
    end
    tick();
    checks++;
    if ({result_o, flags} !== {32'hF8000001, 4'b0100}) begin
      errors++;
      $display("FAIL sra_done: got %h/%b expected %h/%b", result_o, flags, 32'hF8000001, 4'b0100);
    end
    tick();
    start_i = 1'b0;
    checks++;
    if ({result_o, flags} !== {32'h5, 4'b0100}) begin
      errors++;
      $display("FAIL start_in_done_cycle: got %h/%b expected %h/%b", result_o, flags, 32'h5, 4'b0100);
    end
    launch(4'b1000, 32'h0, 32'hDEADBEEF, 5'd0);
    tick();
    start_i = 1'b0;
    checks++;
    if ({result_o, flags} !== {32'hDEADBEEF, 4'b0100}) begin
      errors++;
      $display("FAIL sra_shamt0: got %h/%b expected %h/%b", result_o, flags, 32'hDEADBEEF, 4'b0100);
    end
    tick();
  endtask

  task automatic test_sra_max();
    launch(4'b1000, 32'h0, 32'h80000000, 5'd31);
    tick();
    start_i = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if ({busy_o, done_o} !== 2'b10) begin
        errors++;
        $display("FAIL sra31_busy_%0d: got %b expected %b", i, {busy_o, done_o}, 2'b10);
      end
    end
    tick();
    checks++;
    if ({result_o, flags} !== {32'hFFFFFFFF, 4'b0100}) begin
      errors++;
      $display("FAIL sra31_done: got %h/%b expected %h/%b", result_o, flags, 32'hFFFFFFFF, 4'b0100);
    end
    tick();
  endtask

  task automatic test_reset_midshift();
    launch(4'b1000, 32'h0, 32'h80000000, 5'd31);
    tick();
    start_i = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midshift_busy: got %b expected %b", busy_o, 1'b1);
    end
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    checks++;
    if ({result_o, flags} !== {32'h0, 4'b0010}) begin
      errors++;
      $display("FAIL midshift_reset: got %h/%b expected %h/%b", result_o, flags, 32'h0, 4'b0010);
    end
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
        errors++;
        $display("FAIL abandoned_shift_%0d: got %b expected %b", i, {busy_o, done_o}, 2'b00);
      end
    end
  endtask

  task automatic test_back_to_back();
    launch(4'b0000, 32'h0F, 32'hFF, 5'd0);
    tick();
    launch(4'b0001, 32'hF0, 32'h0F, 5'd0);
    checks++;
    if ({result_o, flags} !== {32'h0F, 4'b0100}) begin
      errors++;
      $display("FAIL b2b_and: got %h/%b expected %h/%b", result_o, flags, 32'h0F, 4'b0100);
    end
    tick();
    launch(4'b1111, 32'h1234, 32'h5678, 5'd3);
    checks++;
    if ({result_o, flags} !== {32'hFF, 4'b0100}) begin
      errors++;
      $display("FAIL b2b_or: got %h/%b expected %h/%b", result_o, flags, 32'hFF, 4'b0100);
    end
    tick();
    start_i = 1'b0;
    checks++;
    if ({result_o, flags} !== {32'h0, 4'b0110}) begin
      errors++;
      $display("FAIL b2b_nop: got %h/%b expected %h/%b", result_o, flags, 32'h0, 4'b0110);
    end
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_end: got %b expected %b", done_o, 1'b0);
    end
  endtask

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b0;
    ctrl_i  = 4'b0;
    src1_i  = '0;
    src2_i  = '0;
    shamt_i = '0;
    test_reset();
    test_addsub();
    test_slt_lui();
    test_sra();
    test_sra_max();
    test_reset_midshift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
